fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the 16x8 synchronous FIFO. Pops one byte at a time through the FIFO's `re`/`empty` read port, captures the registered read data, and serialises it LSB-first as an asynchronous UART frame on `tx`. Sits between the FIFO and the board TX pin, converting buffered parallel bytes into a serial stream with no CPU involvement.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal minimum 2.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  8  FIFO read data; valid only in the cycle after `fifo_re` was sampled high, high-Z otherwise.
- `fifo_re`  out  1  FIFO read enable; single-cycle pulse per byte.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse on the final cycle of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, (PARITY), STOP.
- IDLE: `tx`=1. If `fifo_empty`=0, go to POP; otherwise stay.
- POP: `fifo_re`=1 for exactly this cycle (Moore output, registered state). Always go to LOAD.
- LOAD: `fifo_dout` is valid. Capture it into an 8-bit shift register at the end of the cycle. Clear the baud counter. Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: `tx`=shift[0]. Shift right on each baud tick. A 3-bit bit counter advances 0..7, then the state advances.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `tx_done` pulses on the tick cycle. Then go to IDLE.
- Baud tick: fires when the baud counter equals CLKS_PER_BIT-1. The counter wraps to 0 on the tick and is cleared on LOAD. Its width is $clog2(CLKS_PER_BIT).
- `fifo_re` is never asserted while `fifo_empty`=1. Only one byte is in flight; no read is issued during a frame.
- `fifo_empty` is ignored outside IDLE.
- Reset values: state IDLE, `tx`=1, `fifo_re`=0, `busy`=0, `tx_done`=0, shift register 0, all counters 0.
- Reset mid-frame: on the next edge `tx`=1 and state is IDLE. The byte in flight is discarded and not re-read. The FIFO pointer has already advanced.

## Timing
- Cycle 0: IDLE with `fifo_empty`=0.
- Cycle 1: POP, `fifo_re`=1.
- Cycle 2: LOAD.
- Cycle 3: first cycle of the start bit (`tx`=0).
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- `tx_done` is high in the last cycle of the frame. The next cycle is IDLE.
- Back-to-back: between successive frames the line stays high for the stop bit plus 3 cycles (IDLE, POP, LOAD).

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. `tx` = even parity (XOR of the 8 captured bits) for CLKS_PER_BIT cycles. Frame becomes 11 bits.
- Macro undefined: no PARITY state; 8N1 frame.

## Structure
- Package `uart_pkg` holds:
  - state enum `tx_state_t`;
  - constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1'b1;
  - function `even_parity(logic [7:0])`.
- One sub-module, `baud_gen`: parameter CLKS_PER_BIT; inputs `clk`, `rst`, `clr`; output `tick`. It is instantiated once.

## Test plan
- Reset: assert `rst` during a frame. Next edge: `tx`=1, `busy`=0, `fifo_re`=0, `tx_done`=0. No further reads while `fifo_empty`=1.
- Single byte, CLKS_PER_BIT=4, FIFO holds 0xA5: `fifo_re` pulses once, 1 cycle after empty drops. `tx` falls 3 cycles after empty drops, then 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `tx_done` pulses in cycle 40 of the frame.
- Back-to-back: FIFO holds 0x00, 0xFF. Exactly two `fifo_re` pulses. Frames are decoded as 0x00 then 0xFF. Idle-high gap is 4+3 cycles. `busy` is low for exactly 1 cycle between frames.
- Empty FIFO held for 200 cycles: `fifo_re`=0, `tx`=1, `busy`=0 throughout.
- Reset in DATA bit 3, then FIFO holds 0x3C: the aborted byte is never retransmitted. The next frame decodes as 0x3C with correct start timing.
- With `FIFO_UART_TX_PARITY_EN`, byte 0x07: parity bit = 1, frame is 44 cycles at CLKS_PER_BIT=4. Byte 0x03: parity bit = 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encoding, frame constants and parity helper for the
//            FIFO-drain UART transmitter.
// Revision  : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } tx_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/baud_gen.sv
`default_nettype none
// ============================================================================
// baud_gen : free-running bit-period counter, one-cycle tick every
//            CLKS_PER_BIT clocks, restartable with clr.
// Revision  : 1.0
// ============================================================================
module baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : pops bytes from a synchronous FIFO and sends each as an
//                LSB-first UART frame. FIFO_UART_TX_PARITY_EN adds even parity.
// Revision      : 1.0
// ============================================================================
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_re,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   tx_state_t  state;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic       tick;
   logic       clr;
`ifdef FIFO_UART_TX_PARITY_EN
   logic       par;
`endif

   // Restart the bit period so the start bit is exactly CLKS_PER_BIT long.
   assign clr     = (state == LOAD);
   assign tx_done = (state == STOP) && tick;

   baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tx      <= UART_IDLE_LEVEL;
         fifo_re <= 1'b0;
         busy    <= 1'b0;
         shift   <= '0;
         bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         fifo_re <= 1'b0;
         case (state)
            IDLE: begin
               tx <= UART_IDLE_LEVEL;
               if (!fifo_empty) begin
                  state   <= POP;
                  fifo_re <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            POP: begin
               state <= LOAD;
            end
            LOAD: begin
               shift   <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
               par     <= even_parity(fifo_dout);
`endif
               bit_cnt <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (tick) begin
                  tx    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shift <= {1'b0, shift[7:1]};
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                     tx      <= par;
                     state   <= PARITY;
`else
                     tx      <= UART_IDLE_LEVEL;
                     state   <= STOP;
`endif
                  end else begin
                     // Registered tx leads the shift by one bit.
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shift[1];
                  end
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  tx    <= UART_IDLE_LEVEL;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= UART_IDLE_LEVEL;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_fifo_uart_tx : FIFO model + UART line decoder scoreboard for fifo_uart_tx.
// Revision         : 1.0
// ============================================================================
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   typedef struct {
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_dout;
   logic       fifo_re;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic       wr = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] fq[$];
   exp_t       expq[$];

   int tests = 0;
   int fails = 0;
   int re_cnt = 0;
   int re_viol = 0;

   fifo_uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_re    (fifo_re),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // Synchronous FIFO model: registered read data, registered empty flag.
   always @(posedge clk) begin
      if (fifo_re) begin
         if (fq.size() > 0) fifo_dout <= fq.pop_front();
         else               fifo_dout <= 8'h00;
      end else begin
         fifo_dout <= 'z;
      end
      if (wr) fq.push_back(wdata);
      fifo_empty <= (fq.size() == 0);
   end

   always @(negedge clk) begin
      if (fifo_re) re_cnt++;
      if (!rst && fifo_re && fifo_empty) re_viol++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Line monitor: decodes each frame mid-bit and scores it against expq.
   logic        m_act = 1'b0;
   int          m_cnt = 0;
   logic [10:0] fr;
   logic [10:0] ef;
   exp_t        e;

   always @(negedge clk) begin
      if (rst) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (tx === 1'b0) begin
            m_act = 1'b1;
            m_cnt = 0;
            fr    = '1;
         end
      end else begin
         m_cnt++;
         if ((m_cnt % CPB) == (CPB / 2)) fr[m_cnt / CPB] = tx;
         if (m_cnt == (NB - 1) * CPB + CPB / 2) begin
            m_act = 1'b0;
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL frame_unexpected: got %0h expected none", fr[NB-1:0]);
            end else begin
               e     = expq.pop_front();
               ef    = '1;
               ef[0] = 1'b0;
               ef[8:1] = e.d;
               if (NB == 11) ef[9] = e.p;
               if (fr[NB-1:0] !== ef[NB-1:0]) begin
                  fails++;
                  $display("FAIL frame_decode: got %0h expected %0h", fr[NB-1:0], ef[NB-1:0]);
               end
            end
         end
      end
   end

   // Called on a negedge; the byte lands in the FIFO on the next posedge.
   task automatic write_byte(input logic [7:0] d, input logic p);
      exp_t x;
      x.d = d;
      x.p = p;
      expq.push_back(x);
      wr    = 1'b1;
      wdata = d;
      @(negedge clk);
      wr    = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic p, input logic [10:0] line,
                            input string nm);
      int base;
      int line_err;
      int done_err;
      int busy_err;
      base     = re_cnt;
      line_err = 0;
      done_err = 0;
      busy_err = 0;
      write_byte(d, p);
      for (int c = 1; c <= FRAME + 3; c++) begin
         @(negedge clk);
         if (c == 1) chk({nm, "_re_pulse"}, 32'(fifo_re), 32'd1);
         if (c == 2) chk({nm, "_re_single"}, 32'(fifo_re), 32'd0);
         if (c == 3) chk({nm, "_start_edge"}, 32'(tx), 32'd0);
         if (c >= 3 && c <= 2 + FRAME && tx !== line[(c - 3) / CPB]) line_err++;
         if (c <= 2 + FRAME && busy !== 1'b1) busy_err++;
         if (c == 2 + FRAME) chk({nm, "_tx_done"}, 32'(tx_done), 32'd1);
         else if (tx_done !== 1'b0) done_err++;
         if (c == FRAME + 3) chk({nm, "_idle_after"}, 32'({busy, tx}), 32'b01);
      end
      chk({nm, "_line"}, 32'(line_err), 32'd0);
      chk({nm, "_done_spurious"}, 32'(done_err), 32'd0);
      chk({nm, "_busy_frame"}, 32'(busy_err), 32'd0);
      chk({nm, "_re_count"}, 32'(re_cnt - base), 32'd1);
   endtask

   initial begin
      int base;
      int bl;
      int run;
      int falls;
      int gap;
      int bad;

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_re", 32'(fifo_re), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

`ifdef FIFO_UART_TX_PARITY_EN
      run_frame(8'hA5, 1'b0, 11'b10101001010, "a5");
`else
      run_frame(8'hA5, 1'b0, 11'b01101001010, "a5");
`endif
      repeat (3) @(negedge clk);

      // Back-to-back 0x00 then 0xFF.
      base  = re_cnt;
      bl    = 0;
      run   = 0;
      falls = 0;
      gap   = -1;
      write_byte(8'h00, 1'b0);
      write_byte(8'hFF, 1'b0);
      for (int c = 2; c <= 2 * FRAME + 7; c++) begin
         @(negedge clk);
         if (c <= 2 * FRAME + 5 && busy === 1'b0) bl++;
         if (c == FRAME + 6) chk("b2b_start2", 32'(tx), 32'd0);
         if (tx === 1'b1) begin
            run++;
         end else begin
            if (run > 0) begin
               falls++;
               if (falls == 2) gap = run;
            end
            run = 0;
         end
      end
      chk("b2b_re_count", 32'(re_cnt - base), 32'd2);
      chk("b2b_busy_low", 32'(bl), 32'd1);
      chk("b2b_gap", 32'(gap), 32'd7);
      repeat (3) @(negedge clk);

      // Abort during data bit 3; the byte is consumed and must not reappear.
      base = re_cnt;
      write_byte(8'h55, 1'b0);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_re", 32'(fifo_re), 32'd0);
      chk("mid_rst_done", 32'(tx_done), 32'd0);
      void'(expq.pop_front());
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("mid_rst_no_reread", 32'(re_cnt - base), 32'd1);
      chk("mid_rst_quiet", 32'(bad), 32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
      run_frame(8'h3C, 1'b0, 11'b10001111000, "x3c");
      repeat (3) @(negedge clk);
      run_frame(8'h07, 1'b1, 11'b11000001110, "x07");
      repeat (3) @(negedge clk);
      run_frame(8'h03, 1'b0, 11'b10000000110, "x03");
`else
      run_frame(8'h3C, 1'b0, 11'b01001111000, "x3c");
`endif

      // Empty FIFO for 200 cycles.
      base = re_cnt;
      bad  = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("idle_re", 32'(re_cnt - base), 32'd0);
      chk("idle_line", 32'(bad), 32'd0);

      chk("re_while_empty", 32'(re_viol), 32'd0);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
